line_fill_engine: RTL and testbench
===================================

# line_fill_engine

Renders one scanline of 4-bit palette indices into the pixel line buffer. It runs ahead of the VGA read-out, one line early. On each `line_start` it clears the line to a background index, then composites up to `SPRITES` 16x16 sprites from an external sprite ROM, treating index 0 as transparent. It drives the buffer's write port (`write_address`, `data_In`, `we`) and nothing else.

## Interface
- `LINE_W`, 640, pixels per line; write addresses run 0..LINE_W-1.
- `SPRITES`, 4, number of sprite slots; higher slot number draws on top.

Ports:
- `Clk`  in  1  system clock (pixel clock domain of the line buffer).
- `Reset`  in  1  asynchronous, active-high reset.
- `line_start`  in  1  single-cycle pulse: begin rendering line `line_y`.
- `line_y`  in  10  target line number, 0..479.
- `bg_index`  in  4  background palette index.
- `spr_en`  in  SPRITES  per-slot enable.
- `spr_x`  in  SPRITES x 10  sprite left column.
- `spr_y`  in  SPRITES x 10  sprite top row.
- `spr_id`  in  SPRITES x 4  sprite image number.
- `rom_addr`  out  12  sprite ROM address {id[3:0], row[3:0], col[3:0]}.
- `rom_data`  in  4  ROM pixel index; valid 1 cycle after `rom_addr`.
- `write_address`  out  10  line buffer write address.
- `data_In`  out  4  line buffer write data.
- `we`  out  1  line buffer write enable.
- `busy`  out  1  render in progress.
- `done`  out  1  single-cycle pulse when the line is complete.

## Operation
- States: IDLE, CLEAR, CHECK, DRAW, DONE.
- IDLE: on `line_start`, latch `line_y`, `bg_index`, and all sprite inputs into shadow registers. Set slot k=0 and go to CLEAR. Later input changes do not affect the current line.
- CLEAR: write the latched `bg_index` to addresses 0..LINE_W-1, one per cycle, in ascending order. Then go to CHECK.
- CHECK: slot k is visible iff `spr_en[k]` and `spr_y[k] <= line_y <= spr_y[k]+15`.
  - Evaluate the comparison in 11 bits so `spr_y+15` cannot wrap.
  - Visible: go to DRAW. Not visible: k++.
  - After the last slot, go to DONE.
- DRAW: issue `rom_addr` for col 0..15 with row = (line_y - spr_y[k])[3:0].
  - The write for col c occurs the cycle after its address: `write_address` = spr_x[k]+c, `data_In` = `rom_data`.
  - `we` is high only if `rom_data` != 0 and spr_x[k]+c < LINE_W, computed in 11 bits. Pixels past the right edge are dropped, not wrapped.
  - After the col-15 write, k++ and return to CHECK, or go to DONE if k was last.
- DONE: pulse `done` for 1 cycle, then go to IDLE.
- `line_start` while `busy`: ignored, no restart.
- Overlap: a later slot overwrites an earlier one only where the later slot's pixel is non-zero.
- `Reset` asserted at any time, including mid-line: the FSM returns to IDLE immediately and all outputs go to 0. Line buffer contents are then unspecified until the next full render.

## Timing
- Reset values: `we`=0, `write_address`=0, `data_In`=0, `rom_addr`=0, `busy`=0, `done`=0.
- `line_start` sampled at cycle 0. The first CLEAR write (address 0) is at cycle 1. `busy` is high from cycle 1 through the `done` cycle inclusive.
- CLEAR takes LINE_W cycles. CHECK takes 1 cycle per slot. DRAW takes 17 cycles per visible slot (16 issues plus 1 drain). DONE takes 1 cycle.
- Worst case with defaults: 640 + 4x(1+17) + 1 = 713 cycles. This must fit within the 800-clock line period.
- No all-invisible shortcut: CLEAR always runs in full.
- All outputs are registered. `we`, `write_address`, and `data_In` change together on the same edge.

## Structure
- Package `line_pkg`:
  - constants SPR_DIM=16, TRANSPARENT=4'h0, LINE_ADDR_W=10;
  - typedef `fill_state_t` for the state enum;
  - typedef `sprite_t` packing {en, x, y, id}.
- One sub-module, `sprite_row_fetch`. It takes the DRAW request (id, row, x), runs the 16-column ROM address counter, aligns the 1-cycle `rom_data` latency, and applies the transparency and right-edge checks. The top level owns the FSM, shadow registers, and CLEAR counter.

## Test plan
- Clear only: `bg_index`=4'h3, all `spr_en`=0, `line_start` -> 640 writes of 3 to addresses 0..639 in cycles 1..640, `done` at cycle 645 (after 4 CHECK cycles), `busy` low at cycle 646.
- Single sprite: slot 0 at x=100, y=50, `line_y`=55, ROM row 5 = 0,1,2..15 -> addresses 101..115 written with 1..15, address 100 keeps bg, `done` at cycle 662.
- Priority: slots 0 and 3 at the same x/y, slot 3 ROM non-zero only at even columns -> even columns carry slot 3 data, odd columns carry slot 0 data.
- Right edge: x=630 -> columns 0..9 written to addresses 630..639, no write to any address < 630 after CLEAR, no wrap.
- Visibility bounds: `spr_y`=470 with `line_y`=479 -> visible, row 9; `spr_y`=463 -> not visible; `spr_y`=1020 with `line_y`=5 -> not visible (no 10-bit wrap).
- Robustness: `line_start` pulsed again at cycle 300 -> ignored, single `done`. `Reset` at cycle 400 -> `we`, `busy`, and `done` go to 0 asynchronously, and the next `line_start` renders a correct full line.

Source files
------------

// File: rtl/line_pkg.sv
// Shared types and constants for the scanline fill engine.
package line_pkg;

    localparam int         SPR_DIM     = 16;
    localparam logic [3:0] TRANSPARENT = 4'h0;
    localparam int         LINE_ADDR_W = 10;

    // FSM encoding kept as plain constants so older tools read it unchanged.
    typedef logic [2:0] fill_state_t;
    localparam fill_state_t ST_IDLE  = 3'd0;
    localparam fill_state_t ST_CLEAR = 3'd1;
    localparam fill_state_t ST_CHECK = 3'd2;
    localparam fill_state_t ST_DRAW  = 3'd3;
    localparam fill_state_t ST_DONE  = 3'd4;

    // One sprite slot as captured at line start.
    typedef struct packed {
        logic       en;
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] id;
    } sprite_t;

    // True when line ly falls inside the SPR_DIM rows starting at spr_y.
    // Done in 11 bits so spr_y near the top of the range cannot wrap.
    function automatic logic row_visible(input logic [9:0] spr_y, input logic [9:0] ly);
        logic [10:0] y_top;
        logic [10:0] y_bot;
        logic [10:0] y_cur;
        y_top = {1'b0, spr_y};
        y_bot = y_top + 11'(SPR_DIM - 1);
        y_cur = {1'b0, ly};
        return (y_top <= y_cur) && (y_cur <= y_bot);
    endfunction

endpackage

// File: rtl/sprite_row_fetch.sv
// Fetches one 16-pixel sprite row from the sprite ROM and turns each
// returned pixel into a line buffer write request (address, data, enable).
module sprite_row_fetch
    import line_pkg::*;
#(
    parameter int LINE_W = 640
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   draw_i,
    input  logic [3:0]             id_i,
    input  logic [3:0]             row_i,
    input  logic [9:0]             x_i,
    output logic [11:0]            rom_addr_o,
    input  logic [3:0]             rom_data_i,
    output logic                   row_done_o,
    output logic                   pix_we_o,
    output logic [LINE_ADDR_W-1:0] pix_addr_o,
    output logic [3:0]             pix_data_o
);

    localparam logic [4:0]  COL_END  = 5'(SPR_DIM);
    localparam logic [10:0] LINE_W11 = 11'(LINE_W);

    logic [4:0]  col_q;
    logic        issue_q;
    logic [10:0] px_q;
    logic [11:0] rom_addr_q;
    logic        issuing;

    // Columns 0..15 issue an address; col_q == 16 is the drain cycle that
    // lets the last ROM read come back before the FSM moves on.
    assign issuing    = draw_i && (col_q != COL_END);
    assign row_done_o = draw_i && (col_q == COL_END);

    // Column counter, ROM address and the matching screen column for the
    // pixel that will return next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            issue_q    <= 1'b0;
            px_q       <= '0;
            rom_addr_q <= '0;
        end else begin
            issue_q <= issuing;
            if (issuing) begin
                rom_addr_q <= {id_i, row_i, col_q[3:0]};
                px_q       <= {1'b0, x_i} + {7'd0, col_q[3:0]};
                col_q      <= col_q + 5'd1;
            end else if (draw_i) begin
                col_q <= '0;
            end
        end
    end

    assign rom_addr_o = rom_addr_q;

    // Transparent pixels and columns past the right edge produce no write;
    // the 11-bit column keeps off-screen pixels from aliasing onto column 0.
    assign pix_we_o   = issue_q && (rom_data_i != TRANSPARENT) && (px_q < LINE_W11);
    assign pix_addr_o = px_q[LINE_ADDR_W-1:0];
    assign pix_data_o = rom_data_i;

endmodule

// File: rtl/line_fill_engine.sv
// Renders one scanline of palette indices into the line buffer: clears the
// line to the background index, then composites the visible sprites in slot
// order so that higher slots land on top.
module line_fill_engine
    import line_pkg::*;
#(
    parameter int LINE_W  = 640,
    parameter int SPRITES = 4
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      line_start,
    input  logic [9:0]                line_y,
    input  logic [3:0]                bg_index,
    input  logic [SPRITES-1:0]        spr_en,
    input  logic [SPRITES-1:0][9:0]   spr_x,
    input  logic [SPRITES-1:0][9:0]   spr_y,
    input  logic [SPRITES-1:0][3:0]   spr_id,
    output logic [11:0]               rom_addr,
    input  logic [3:0]                rom_data,
    output logic [LINE_ADDR_W-1:0]    write_address,
    output logic [3:0]                data_In,
    output logic                      we,
    output logic                      busy,
    output logic                      done
);

    localparam int                     KW       = (SPRITES > 1) ? $clog2(SPRITES) : 1;
    localparam logic [KW-1:0]          K_LAST   = KW'(SPRITES - 1);
    localparam logic [LINE_ADDR_W-1:0] CLR_LAST = LINE_ADDR_W'(LINE_W - 1);

    fill_state_t            state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [LINE_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [9:0]             ly_q;
    logic [3:0]             bg_q;
    sprite_t                spr_q  [SPRITES];
    sprite_t                spr_in [SPRITES];
    sprite_t                cur;

    logic                   we_q;
    logic [LINE_ADDR_W-1:0] wr_addr_q;
    logic [3:0]             wr_data_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   start_accept;
    logic                   k_last;
    logic                   cur_visible;
    logic [3:0]             cur_row;
    logic                   draw_active;
    logic                   row_done;
    logic                   pix_we;
    logic [LINE_ADDR_W-1:0] pix_addr;
    logic [3:0]             pix_data;

    // Gather the per-slot input buses into sprite records.
    generate
        for (genvar gi = 0; gi < SPRITES; gi++) begin : g_slot_in
            assign spr_in[gi] = {spr_en[gi], spr_x[gi], spr_y[gi], spr_id[gi]};
        end
    endgenerate

    // A new line is only taken once the previous one, including its done
    // cycle, has fully retired.
    assign start_accept = line_start && (state_q == ST_IDLE) && !busy_q;

    assign cur         = spr_q[k_q];
    assign k_last      = (k_q == K_LAST);
    assign cur_visible = cur.en && row_visible(cur.y, ly_q);
    // Only the low 4 bits of the row offset matter once visibility holds.
    assign cur_row     = ly_q[3:0] - cur.y[3:0];
    assign draw_active = (state_q == ST_DRAW);

    // Shadow copy of the line parameters so input changes mid-render are ignored.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ly_q <= '0;
            bg_q <= '0;
            for (int i = 0; i < SPRITES; i++) begin
                spr_q[i] <= '0;
            end
        end else if (start_accept) begin
            ly_q <= line_y;
            bg_q <= bg_index;
            for (int i = 0; i < SPRITES; i++) begin
                spr_q[i] <= spr_in[i];
            end
        end
    end

    // Next-state logic: clear sweep, per-slot visibility test, row draw.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    state_d   = ST_CLEAR;
                    k_d       = '0;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (cur_visible) begin
                    state_d = ST_DRAW;
                end else if (k_last) begin
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAW: begin
                if (row_done) begin
                    if (k_last) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, slot index and clear address registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    sprite_row_fetch #(
        .LINE_W (LINE_W)
    ) u_fetch (
        .clk        (Clk),
        .rst        (Reset),
        .draw_i     (draw_active),
        .id_i       (cur.id),
        .row_i      (cur_row),
        .x_i        (cur.x),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .row_done_o (row_done),
        .pix_we_o   (pix_we),
        .pix_addr_o (pix_addr),
        .pix_data_o (pix_data)
    );

    // Output stage: the clear sweep and sprite pixels share one registered
    // write port; the two never overlap in time.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            we_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (state_q == ST_CLEAR) begin
                we_q      <= 1'b1;
                wr_addr_q <= clr_cnt_q;
                wr_data_q <= bg_q;
            end else begin
                we_q      <= pix_we;
                wr_addr_q <= pix_addr;
                wr_data_q <= pix_data;
            end
            busy_q <= (state_q != ST_IDLE);
            done_q <= (state_q == ST_DONE);
        end
    end

    assign we            = we_q;
    assign write_address = wr_addr_q;
    assign data_In       = wr_data_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_line_fill_engine.sv
// Directed bench for line_fill_engine: a sprite ROM model and a line buffer
// model driven by the DUT write port, one line of text per rendered line.
module tb_line_fill_engine;

    logic            Clk;
    logic            Reset;
    logic            line_start;
    logic [9:0]      line_y;
    logic [3:0]      bg_index;
    logic [3:0]      spr_en;
    logic [3:0][9:0] spr_x;
    logic [3:0][9:0] spr_y;
    logic [3:0][3:0] spr_id;
    logic [11:0]     rom_addr;
    logic [3:0]      rom_data;
    logic [9:0]      write_address;
    logic [3:0]      data_In;
    logic            we;
    logic            busy;
    logic            done;

    logic [3:0] rom_mem [4096];
    logic [3:0] lbuf    [640];
    logic       fill_req;
    int         oob_cnt = 0;

    int n_assert = 0;
    int n_fail   = 0;

    int r_busy1, r_clr_err, r_done_cyc, r_done_cnt, r_busy_fall;
    int r_draw_wr, r_draw_first, r_draw_min, r_draw_max, r_rom642;

    line_fill_engine #(
        .LINE_W  (640),
        .SPRITES (4)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .line_start    (line_start),
        .line_y        (line_y),
        .bg_index      (bg_index),
        .spr_en        (spr_en),
        .spr_x         (spr_x),
        .spr_y         (spr_y),
        .spr_id        (spr_id),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .write_address (write_address),
        .data_In       (data_In),
        .we            (we),
        .busy          (busy),
        .done          (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Sprite ROM: data for the registered address is available in the following cycle.
    assign rom_data = rom_mem[rom_addr];

    // Line buffer model fed by the DUT write port.
    always @(posedge Clk) begin
        if (fill_req) begin
            for (int i = 0; i < 640; i++) lbuf[i] <= 4'hF;
        end else if (we) begin
            if (write_address < 10'd640) lbuf[write_address] <= data_In;
            else oob_cnt <= oob_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Render one line. Cycle n is the cycle n clocks after the edge that
    // samples line_start. Inputs are scrambled after the start to show that
    // the DUT works from its captured copy.
    task automatic run_line(input logic [9:0] ly, input logic [3:0] bg, input logic [3:0] en,
                            input int restart_at, input int reset_at);
        r_busy1 = 0; r_clr_err = 0; r_done_cyc = 0; r_done_cnt = 0; r_busy_fall = 0;
        r_draw_wr = 0; r_draw_first = 0; r_draw_min = 1023; r_draw_max = 0; r_rom642 = 0;
        fill_req = 1'b1;
        tick();
        fill_req   = 1'b0;
        line_y     = ly;
        bg_index   = bg;
        spr_en     = en;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        line_y     = ~ly;
        bg_index   = ~bg;
        spr_en     = ~en;
        spr_y      = ~spr_y;
        for (int n = 1; n <= 1000; n++) begin
            tick();
            if (n == 1) r_busy1 = int'(busy);
            if (n <= 640) begin
                if (!(we === 1'b1 && write_address === 10'(n - 1) && data_In === bg)) r_clr_err++;
            end else if (we === 1'b1) begin
                r_draw_wr++;
                if (r_draw_first == 0) r_draw_first = n;
                if (int'(write_address) < r_draw_min) r_draw_min = int'(write_address);
                if (int'(write_address) > r_draw_max) r_draw_max = int'(write_address);
            end
            if (n == 642) r_rom642 = int'(rom_addr);
            if (done === 1'b1) begin
                r_done_cnt++;
                if (r_done_cyc == 0) r_done_cyc = n;
            end
            if (busy === 1'b0 && r_busy_fall == 0) r_busy_fall = n;
            line_start = (n == restart_at);
            if (n == reset_at) begin
                #2;
                Reset = 1'b1;
                #1;
                check("rst_mid_we", we, 0);
                check("rst_mid_busy", busy, 0);
                check("rst_mid_done", done, 0);
                check("rst_mid_addr", write_address, 0);
                check("rst_mid_data", data_In, 0);
                break;
            end
        end
        line_start = 1'b0;
        $display("line y=%0d bg=%0d: done at %0d, %0d sprite writes, addr %0d..%0d",
                 ly, bg, r_done_cyc, r_draw_wr, r_draw_min, r_draw_max);
    endtask

    initial begin
        int bad;
        Reset = 1'b0; line_start = 1'b0; line_y = '0; bg_index = '0;
        spr_en = '0; spr_x = '0; spr_y = '0; spr_id = '0; fill_req = 1'b0;
        for (int i = 0; i < 4096; i++) rom_mem[i] = 4'h0;
        for (int c = 0; c < 16; c++) begin
            rom_mem[{4'd2, 4'd5, 4'(c)}] = 4'(c);
            rom_mem[{4'd1, 4'd2, 4'(c)}] = 4'h5;
            rom_mem[{4'd3, 4'd2, 4'(c)}] = (c % 2 == 0) ? 4'hA : 4'h0;
            rom_mem[{4'd4, 4'd3, 4'(c)}] = 4'h9;
            rom_mem[{4'd5, 4'd9, 4'(c)}] = 4'hC;
            for (int r = 0; r < 16; r++) begin
                rom_mem[{4'd6, 4'(r), 4'(c)}] = 4'hD;
                rom_mem[{4'd7, 4'(r), 4'(c)}] = 4'hE;
            end
        end

        // Reset values
        #2 Reset = 1'b1;
        #1;
        check("rst_we", we, 0);
        check("rst_addr", write_address, 0);
        check("rst_data", data_In, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;

        // Clear only
        run_line(10'd0, 4'h3, 4'b0000, 0, 0);
        check("clr_busy1", r_busy1, 1);
        check("clr_writes", r_clr_err, 0);
        check("clr_done_cyc", r_done_cyc, 645);
        check("clr_done_cnt", r_done_cnt, 1);
        check("clr_busy_fall", r_busy_fall, 646);
        check("clr_draw_wr", r_draw_wr, 0);
        bad = 0;
        for (int i = 0; i < 640; i++) if (lbuf[i] !== 4'h3) bad++;
        check("clr_buffer", bad, 0);

        // Single sprite, slot 0 at x=100 y=50, line 55 -> ROM row 5
        spr_x = '0; spr_y = '0; spr_id = '0;
        spr_x[0] = 10'd100; spr_y[0] = 10'd50; spr_id[0] = 4'd2;
        run_line(10'd55, 4'h8, 4'b0001, 0, 0);
        check("one_done_cyc", r_done_cyc, 662);
        check("one_rom_addr", r_rom642, 12'h250);
        check("one_first_wr", r_draw_first, 644);
        check("one_wr_cnt", r_draw_wr, 15);
        check("one_min", r_draw_min, 101);
        check("one_max", r_draw_max, 115);
        check("one_px100", lbuf[100], 4'h8);
        check("one_px116", lbuf[116], 4'h8);
        bad = 0;
        for (int c = 1; c < 16; c++) if (lbuf[100 + c] !== 4'(c)) bad++;
        check("one_pixels", bad, 0);

        // Priority: slots 0 and 3 overlap, slot 3 opaque only on even columns
        spr_x = '0; spr_y = '0; spr_id = '0;
        spr_x[0] = 10'd200; spr_y[0] = 10'd10; spr_id[0] = 4'd1;
        spr_x[3] = 10'd200; spr_y[3] = 10'd10; spr_id[3] = 4'd3;
        run_line(10'd12, 4'h2, 4'b1001, 0, 0);
        check("prio_done_cyc", r_done_cyc, 679);
        check("prio_wr_cnt", r_draw_wr, 24);
        check("prio_first_wr", r_draw_first, 643);
        for (int c = 0; c < 16; c += 5) begin
            check("prio_px", lbuf[200 + c], (c % 2 == 0) ? 4'hA : 4'h5);
        end
        check("prio_px215", lbuf[215], 4'h5);
        check("prio_px199", lbuf[199], 4'h2);

        // Right edge: slot 1 at x=630
        spr_x = '0; spr_y = '0; spr_id = '0;
        spr_x[1] = 10'd630; spr_y[1] = 10'd0; spr_id[1] = 4'd4;
        run_line(10'd3, 4'h6, 4'b0010, 0, 0);
        check("edge_done_cyc", r_done_cyc, 662);
        check("edge_wr_cnt", r_draw_wr, 10);
        check("edge_min", r_draw_min, 630);
        check("edge_max", r_draw_max, 639);
        check("edge_oob", oob_cnt, 0);
        check("edge_px639", lbuf[639], 4'h9);
        check("edge_px629", lbuf[629], 4'h6);
        check("edge_px0", lbuf[0], 4'h6);

        // Visibility: bottom line of a sprite at y=470, one just above, one disabled
        spr_x = '0; spr_y = '0; spr_id = '0;
        spr_x[0] = 10'd0;  spr_y[0] = 10'd470; spr_id[0] = 4'd5;
        spr_x[1] = 10'd20; spr_y[1] = 10'd463; spr_id[1] = 4'd6;
        spr_x[3] = 10'd60; spr_y[3] = 10'd470; spr_id[3] = 4'd5;
        run_line(10'd479, 4'h1, 4'b0011, 0, 0);
        check("vis_done_cyc", r_done_cyc, 662);
        check("vis_wr_cnt", r_draw_wr, 16);
        check("vis_max", r_draw_max, 15);
        check("vis_px0", lbuf[0], 4'hC);
        check("vis_px20", lbuf[20], 4'h1);
        check("vis_px60", lbuf[60], 4'h1);

        // Visibility: sprite at y=1020 must not wrap onto line 5
        spr_x = '0; spr_y = '0; spr_id = '0;
        spr_x[2] = 10'd40; spr_y[2] = 10'd1020; spr_id[2] = 4'd7;
        run_line(10'd5, 4'h4, 4'b0100, 0, 0);
        check("wrap_done_cyc", r_done_cyc, 645);
        check("wrap_wr_cnt", r_draw_wr, 0);
        check("wrap_px40", lbuf[40], 4'h4);

        // Second line_start while busy is ignored
        spr_x = '0; spr_y = '0; spr_id = '0;
        run_line(10'd100, 4'h1, 4'b0000, 300, 0);
        check("restart_done_cnt", r_done_cnt, 1);
        check("restart_done_cyc", r_done_cyc, 645);
        check("restart_clr", r_clr_err, 0);

        // Reset mid-line, then a full render
        run_line(10'd100, 4'h2, 4'b0000, 0, 400);
        @(posedge Clk);
        #1 Reset = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);
        spr_x = '0; spr_y = '0; spr_id = '0;
        spr_x[0] = 10'd100; spr_y[0] = 10'd50; spr_id[0] = 4'd2;
        run_line(10'd55, 4'h4, 4'b0001, 0, 0);
        check("rerun_clr", r_clr_err, 0);
        check("rerun_done_cyc", r_done_cyc, 662);
        check("rerun_wr_cnt", r_draw_wr, 15);
        check("rerun_px100", lbuf[100], 4'h4);
        check("rerun_px115", lbuf[115], 4'hF);
        check("rerun_px0", lbuf[0], 4'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
